// File: rtl/opl2_reg_wr_scheduler.sv
// opl2_reg_wr_scheduler
//  Merges two register-write requesters into one opl2_reg_wr stream:
//  requester 0 is the host bus, requester 1 is the internal/debug port.
//  - Round-robin arbitration: when both requesters are valid, the one that was
//    not granted last wins.
//  - After each accepted write, WR_GAP_CYCLES idle cycles are enforced.
//  - opl2_reg_wr is a flat vector laid out as {valid, address, data}.
//  Optional feature, macro OPL2_IRQ_RST_PRESERVE_EN:
//  - A reg 4 write with data[7] set (IRQ-RST) is issued with the last written
//    mask/start bits, as the real chip does.
//  - Without the macro, data passes through untouched and no shadow exists.
module opl2_reg_wr_scheduler #(
    parameter int WR_GAP_CYCLES = 84,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req0_valid,
    output logic                           req0_ready,
    input  logic [ADDR_WIDTH-1:0]          req0_address,
    input  logic [DATA_WIDTH-1:0]          req0_data,
    input  logic                           req1_valid,
    output logic                           req1_ready,
    input  logic [ADDR_WIDTH-1:0]          req1_address,
    input  logic [DATA_WIDTH-1:0]          req1_data,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] opl2_reg_wr,
    output logic                           busy,
    output logic                           last_grant
);

    typedef enum logic {IDLE, GAP} state_t;

    // A zero gap still needs a legal one-bit counter, even though it is never loaded
    localparam int CNT_W = (WR_GAP_CYCLES > 0) ? $clog2(WR_GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WR_GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] IRQ_REG_ADDR = ADDR_WIDTH'(4);

    state_t                 state;
    logic [CNT_W-1:0]       gap_count;
    logic                   grant0;
    logic                   grant1;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  sel_address;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [DATA_WIDTH-1:0]  issue_data;

`ifdef OPL2_IRQ_RST_PRESERVE_EN
    logic [6:0]             shadow;
    logic                   irq_rst_write;
`endif

    // Arbitration: grant at most one requester, only while IDLE and out of reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign accept      = grant0 | grant1;
    assign sel_address = grant1 ? req1_address : req0_address;
    assign sel_data    = grant1 ? req1_data    : req0_data;

`ifdef OPL2_IRQ_RST_PRESERVE_EN
    assign irq_rst_write = (sel_address == IRQ_REG_ADDR) && sel_data[7];

    // IRQ-RST writes keep the previously written timer mask/start bits
    always_comb begin
        issue_data = sel_data;
        if (irq_rst_write) begin
            issue_data[6:0] = shadow;
            issue_data[7]   = 1'b1;
        end
    end

    // Track the mask/start bits of every ordinary reg 4 write as it is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (accept && sel_address == IRQ_REG_ADDR && !irq_rst_write) begin
            shadow <= sel_data[6:0];
        end
    end
`else
    assign issue_data = sel_data;
`endif

    // Sequencer: one-cycle write pulse after each accept, then the enforced gap
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gap_count   <= '0;
            opl2_reg_wr <= '0;
            busy        <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            opl2_reg_wr <= accept ? {1'b1, sel_address, issue_data} : '0;
            busy        <= accept || (state == GAP && gap_count != GAP_LAST);
            if (accept) begin
                last_grant <= grant1;
            end
            case (state)
                IDLE: begin
                    if (accept && WR_GAP_CYCLES > 0) begin
                        state     <= GAP;
                        gap_count <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_count == GAP_LAST) begin
                        state     <= IDLE;
                        gap_count <= '0;
                    end else begin
                        gap_count <= gap_count - GAP_LAST;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gap_count <= '0;
                end
            endcase
        end
    end

endmodule
